// File: rtl/mem_dp_responder_pkg.sv
// Shared definitions for the dual-port memory responder: default widths,
// the depth helper and the collision-mode selector (package mem_pkg).
package mem_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int ADDR_BITS_DEF = 6;

    // Number of words addressed by an address of the given width.
    function automatic int mem_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    // Behaviour of a read that hits the address being written in the same cycle.
    typedef enum logic {
        WRITE_FIRST = 1'b0,
        READ_FIRST  = 1'b1
    } collision_mode_e;

endpackage

// File: rtl/mem_dp_responder_if.sv
// Write/read strobe bus between a stimulus driver (master) and the memory
// responder (slave), plus the responder's read-data and status returns.
interface mem_dp_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF
) ();

    logic [DATA_BITS-1:0] data_in;
    logic [ADDR_BITS-1:0] addr_write;
    logic [ADDR_BITS-1:0] addr_read;
    logic                 write;
    logic                 read;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid_out;
    logic                 err_uninit;
    logic [ADDR_BITS:0]   used_count;

    modport master (
        output data_in, addr_write, addr_read, write, read,
        input  data_out, valid_out, err_uninit, used_count
    );

    modport slave (
        input  data_in, addr_write, addr_read, write, read,
        output data_out, valid_out, err_uninit, used_count
    );

endinterface

// File: rtl/mem_dp_responder_array.sv
// Pure word storage: one synchronous write port, one combinational read port.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    localparam int DEPTH = mem_depth(ADDR_BITS);

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Store the incoming word on a write strobe.
    // NOTE: the array has no reset; its contents only become visible once the
    // written-flags held by the parent are set, and leaving it unreset lets
    // synthesis map it onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_dp_responder.sv
// Memory-side responder for the dual-port write/read strobe bus.
// Stores words, returns registered read data one cycle after a read strobe,
// flags reads of never-written locations and counts distinct written addresses.
// Build option: define MEM_READ_FIRST_EN to make a same-address, same-cycle
// write/read return the old content instead of the word being written.
module mem_dp_responder
    import mem_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input logic              clk,
    input logic              reset_L,
    mem_dp_responder_if.slave bus
);

    localparam int DEPTH = mem_depth(ADDR_BITS);

`ifdef MEM_READ_FIRST_EN
    localparam collision_mode_e COLL_MODE = READ_FIRST;
`else
    localparam collision_mode_e COLL_MODE = WRITE_FIRST;
`endif

    logic [DEPTH-1:0]     written_q,    written_d;
    logic [ADDR_BITS:0]   used_count_q, used_count_d;
    logic [DATA_BITS-1:0] data_out_q,   data_out_d;
    logic                 valid_q,      valid_d;
    logic                 err_q,        err_d;

    logic [DATA_BITS-1:0] rd_data;
    logic                 same_addr;
    logic                 bypass;

    mem_array #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .wr_en   (bus.write),
        .wr_addr (bus.addr_write),
        .wr_data (bus.data_in),
        .rd_addr (bus.addr_read),
        .rd_data (rd_data)
    );

    // In write-first mode a colliding read forwards the incoming word; in
    // read-first mode it falls through to the pre-write content and flag.
    assign same_addr = bus.write && (bus.addr_write == bus.addr_read);
    assign bypass    = same_addr && (COLL_MODE == WRITE_FIRST);

    // Next-state for written-flags, occupancy counter and read response.
    // NOTE: every signal gets a default at the top of the block so that no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        written_d    = written_q;
        used_count_d = used_count_q;
        data_out_d   = data_out_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;

        if (bus.write) begin
            written_d[bus.addr_write] = 1'b1;
            if (!written_q[bus.addr_write]) begin
                used_count_d = used_count_q + (ADDR_BITS+1)'(1);
            end
        end

        if (bus.read) begin
            valid_d = 1'b1;
            if (bypass) begin
                data_out_d = bus.data_in;
            end else if (!written_q[bus.addr_read]) begin
                data_out_d = '0;
                err_d      = 1'b1;
            end else begin
                data_out_d = rd_data;
            end
        end
    end

    // Register flags, counter and read response; reset discards any read in flight.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            written_q    <= '0;
            used_count_q <= '0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            written_q    <= written_d;
            used_count_q <= used_count_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = valid_q;
    assign bus.err_uninit = err_q;
    assign bus.used_count = used_count_q;

endmodule

// File: doc/mem_dp_responder.md
Name: mem_dp_responder

Overview:
- Memory-side responder for the simple dual-port write/read strobe interface.
- Uses the same signals the team's stimulus driver produces: data_in, addr_write, addr_read, write, read.
- Stores words and returns registered read data with a valid strobe.
- Tracks which addresses hold written data, flags reads of never-written locations, and counts distinct occupied addresses.
- Sits directly below any producer/consumer pair sharing one address space.

Parameters:
- DATA_BITS, 8, word width.
- ADDR_BITS, 6, address width; depth is DEPTH = 2**ADDR_BITS (localparam).

Ports:
- clk  input  1  rising-edge clock
- reset_L  input  1  asynchronous, active-low reset
- data_in  input  DATA_BITS  write data
- addr_write  input  ADDR_BITS  write address
- addr_read  input  ADDR_BITS  read address
- write  input  1  write strobe, sampled at posedge clk
- read  input  1  read strobe, sampled at posedge clk
- data_out  output  DATA_BITS  registered read data
- valid_out  output  1  data_out valid, one-cycle pulse per accepted read
- err_uninit  output  1  accompanies valid_out when the read location was never written since reset
- used_count  output  ADDR_BITS+1  number of distinct addresses written since reset, 0..DEPTH

Behaviour:
- Reset (reset_L=0, asynchronous):
  - data_out=0, valid_out=0, err_uninit=0, used_count=0.
  - All DEPTH written-flags cleared; any read accepted in the cycle of reset is discarded.
  - Array contents are not cleared; they are never observable because the written-flags are clear.
- Write: at posedge with write=1, mem[addr_write]<=data_in.
  - If written-flag[addr_write] was 0: set it and increment used_count.
  - Rewrites of a flagged address leave used_count unchanged.
  - used_count never exceeds DEPTH; this is reached exactly when every address is flagged.
- Read: at posedge with read=1, on the next cycle valid_out=1 and data_out=mem[addr_read].
  - Latency is one cycle; back-to-back reads give back-to-back valid pulses.
  - With read=0: valid_out=0, err_uninit=0, and data_out holds its last value.
- Uninitialized read: written-flag[addr_read]=0 and no same-cycle write to that address.
  - Response: data_out=0, valid_out=1, err_uninit=1.
- Simultaneous write and read, different addresses: independent; the read returns the pre-existing content.
- Simultaneous write and read, same address: default write-first.
  - data_out=data_in of that cycle, err_uninit=0.
  - The flag and used_count update as for a normal write.
- write and read are fully independent strobes; no backpressure, no ready signal.
- Addresses are always in range (full-width decode); there is no wrap logic beyond natural ADDR_BITS width.
- Reset deasserting mid-stream: the first strobes sampled at the following posedge are processed normally.

Optional Feature:
- MEM_READ_FIRST_EN defined:
  - A same-address same-cycle collision returns the old content.
  - err_uninit=1 and data_out=0 if that address was unflagged before the write.
- MEM_READ_FIRST_EN undefined: write-first as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package mem_pkg holds:
  - Default DATA_BITS/ADDR_BITS constants.
  - Function mem_depth(addr_bits) returning 2**addr_bits.
  - Collision-mode enum (WRITE_FIRST, READ_FIRST) used for internal selection.
- One sub-module, mem_array: pure storage with one synchronous write port and one combinational read port, parameterized by DATA_BITS/ADDR_BITS.
- mem_dp_responder owns the flags, counter, output registers and collision logic.

Test Plan:
- Reset low, then high; write 255 to addr 0; next cycle read addr 0 -> one cycle later data_out=255, valid_out=1, err_uninit=0, used_count=1.
- Read addr 5 after reset without writing -> data_out=0, valid_out=1, err_uninit=1.
- Streaming sequence: 25 cycles of write addr k+1 with random data while reading addr k -> each valid_out pulse returns the data written to addr k; used_count ends at 26.
- Write 8'hA5 and read addr 3 in the same cycle (addr 3 previously 8'h11):
  - Default build -> data_out=8'hA5.
  - MEM_READ_FIRST_EN build -> data_out=8'h11.
- Write all 64 addresses, then rewrite addr 0 -> used_count=64 and stays 64.
- Assert reset_L low in the cycle after a read strobe -> valid_out never pulses, used_count=0; a subsequent read of a previously written address -> err_uninit=1.
